// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register target.
package axil_pkg;

   localparam int C_AXI_STRB_WIDTH = 4;

   // AXI response codes used by this target
   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   // Write-side FSM encoding
   typedef logic [2:0] wr_state_t;
   localparam wr_state_t WR_IDLE    = 3'd0;
   localparam wr_state_t WR_HAVE_AW = 3'd1;
   localparam wr_state_t WR_HAVE_W  = 3'd2;
   localparam wr_state_t WR_COMMIT  = 3'd3;
   localparam wr_state_t WR_RESP    = 3'd4;

   // Read-side FSM encoding
   typedef logic [0:0] rd_state_t;
   localparam rd_state_t RD_IDLE = 1'b0;
   localparam rd_state_t RD_RESP = 1'b1;

   // Width of the register index field within the byte address
   function automatic int idx_width(input int num_regs);
      return $clog2(num_regs);
   endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register target: a bank of word-wide R/W registers exposed in
// parallel to fabric, with a one-cycle write pulse per register.
module axil_reg_slave
   import axil_pkg::*;
#(
   parameter int P_AXI_ADDR_WIDTH = 13,
   parameter int P_AXI_DATA_WIDTH = 32,
   parameter int P_NUM_REGS       = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [P_AXI_ADDR_WIDTH-1:0]            s_axi_awaddr,
   input  logic                                   s_axi_awvalid,
   output logic                                   s_axi_awready,
   input  logic [P_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
   input  logic [C_AXI_STRB_WIDTH-1:0]            s_axi_wstrb,
   input  logic                                   s_axi_wvalid,
   output logic                                   s_axi_wready,
   output logic [1:0]                             s_axi_bresp,
   output logic                                   s_axi_bvalid,
   input  logic                                   s_axi_bready,
   input  logic [P_AXI_ADDR_WIDTH-1:0]            s_axi_araddr,
   input  logic                                   s_axi_arvalid,
   output logic                                   s_axi_arready,
   output logic [P_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
   output logic [1:0]                             s_axi_rresp,
   output logic                                   s_axi_rvalid,
   input  logic                                   s_axi_rready,
   output logic [P_NUM_REGS*P_AXI_DATA_WIDTH-1:0] reg_out,
   output logic [P_NUM_REGS-1:0]                  reg_wr_pulse
);

   localparam int AW      = P_AXI_ADDR_WIDTH;
   localparam int DW      = P_AXI_DATA_WIDTH;
   localparam int IW      = idx_width(P_NUM_REGS);
   localparam int LSB_OOR = 2 + IW;

   // Any address bit above the index field marks the access out of range
   function automatic logic in_range(input logic [AW-1:0] a);
      return ((a >> LSB_OOR) == '0);
   endfunction

   logic [P_NUM_REGS-1:0][DW-1:0] regs;
   assign reg_out = regs;

   // ---------------- write path ----------------
   wr_state_t                   wr_state, wr_next;
   logic [AW-1:0]               awaddr_q;
   logic [DW-1:0]               wdata_q;
   logic [C_AXI_STRB_WIDTH-1:0] wstrb_q;
   logic                        aw_hs, w_hs, commit_go, wr_ok;
   logic [AW-1:0]               wr_addr;
   logic [DW-1:0]               wr_data;
   logic [C_AXI_STRB_WIDTH-1:0] wr_strb;
   logic [IW-1:0]               wr_idx;

   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid & s_axi_wready;

   // A channel completing this cycle supplies its fields directly, otherwise the held copy
   assign wr_addr   = aw_hs ? s_axi_awaddr : awaddr_q;
   assign wr_data   = w_hs  ? s_axi_wdata  : wdata_q;
   assign wr_strb   = w_hs  ? s_axi_wstrb  : wstrb_q;
   assign wr_idx    = wr_addr[2 +: IW];
   assign wr_ok     = in_range(wr_addr);
   assign commit_go = (wr_next == WR_COMMIT);

   // Write FSM next state: collect AW and W in any order, then respond
   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE: begin
            if (aw_hs && w_hs) wr_next = WR_COMMIT;
            else if (aw_hs)    wr_next = WR_HAVE_AW;
            else if (w_hs)     wr_next = WR_HAVE_W;
         end
         WR_HAVE_AW: if (w_hs)  wr_next = WR_COMMIT;
         WR_HAVE_W:  if (aw_hs) wr_next = WR_COMMIT;
         WR_COMMIT, WR_RESP: wr_next = s_axi_bready ? WR_IDLE : WR_RESP;
         default: wr_next = WR_IDLE;
      endcase
   end

   // Write FSM state, registered handshake outputs and held AW/W fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_state      <= WR_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         reg_wr_pulse  <= '0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
      end else begin
         wr_state      <= wr_next;
         s_axi_awready <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_W);
         s_axi_wready  <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_AW);
         s_axi_bvalid  <= (wr_next == WR_COMMIT) || (wr_next == WR_RESP);
         reg_wr_pulse  <= '0;
         if (aw_hs) awaddr_q <= s_axi_awaddr;
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         if (commit_go) begin
            s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) reg_wr_pulse[wr_idx] <= 1'b1;
         end
      end
   end

   // Register bank: byte-strobed update on an in-range commit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs <= '0;
      end else if (commit_go && wr_ok) begin
         for (int b = 0; b < C_AXI_STRB_WIDTH; b++)
            if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   // ---------------- read path ----------------
   rd_state_t     rd_state, rd_next;
   logic          ar_hs;
   logic [IW-1:0] rd_idx;

   assign ar_hs  = s_axi_arvalid & s_axi_arready;
   assign rd_idx = s_axi_araddr[2 +: IW];

   // Read FSM next state: one outstanding read, held until accepted
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_hs)        rd_next = RD_RESP;
         RD_RESP: if (s_axi_rready) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   // Read FSM state and registered R channel; samples the pre-commit bank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state      <= RD_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= RESP_OKAY;
      end else begin
         rd_state      <= rd_next;
         s_axi_arready <= (rd_next == RD_IDLE);
         s_axi_rvalid  <= (rd_next == RD_RESP);
         if (ar_hs) begin
            if (in_range(s_axi_araddr)) begin
               s_axi_rdata <= regs[rd_idx];
               s_axi_rresp <= RESP_OKAY;
            end else begin
               s_axi_rdata <= '0;
               s_axi_rresp <= RESP_SLVERR;
            end
         end
      end
   end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT presents B/R.
module tb_axil_reg_slave;

   localparam int NR = 8;
   localparam int RW = NR * 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [12:0]   s_axi_awaddr = '0;
   logic          s_axi_awvalid = 1'b0;
   logic          s_axi_awready;
   logic [31:0]   s_axi_wdata = '0;
   logic [3:0]    s_axi_wstrb = '0;
   logic          s_axi_wvalid = 1'b0;
   logic          s_axi_wready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid;
   logic          s_axi_bready = 1'b1;
   logic [12:0]   s_axi_araddr = '0;
   logic          s_axi_arvalid = 1'b0;
   logic          s_axi_arready;
   logic [31:0]   s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rvalid;
   logic          s_axi_rready = 1'b1;
   logic [RW-1:0] reg_out;
   logic [NR-1:0] reg_wr_pulse;

   axil_reg_slave #(.P_AXI_ADDR_WIDTH(13), .P_AXI_DATA_WIDTH(32), .P_NUM_REGS(NR)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    resp;
      logic [NR-1:0] pulse;
      logic [RW-1:0] regs;
   } b_exp_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   typedef struct {
      string         name;
      logic [RW-1:0] act;
      logic [RW-1:0] exp;
   } chk_t;

   b_exp_t b_q[$];
   r_exp_t r_q[$];
   chk_t   chk_q[$];

   logic [RW-1:0] model = '0;
   int n_vec = 0;
   int n_err = 0;

   // ---------------- monitor ----------------
   task automatic compare(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin : monitor
      chk_t   c;
      b_exp_t be;
      r_exp_t re;
      logic   bv_prev = 1'b0;
      logic   rv_prev = 1'b0;
      logic [31:0] rhold = '0;
      forever begin
         @(negedge clk);
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compare(c.name, c.act, c.exp);
         end
         if (rst) begin
            if (s_axi_bvalid && !bv_prev) begin
               if (b_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL b_unexpected: got bvalid=1 expected no response");
               end else begin
                  be = b_q.pop_front();
                  compare("bresp", RW'(s_axi_bresp), RW'(be.resp));
                  compare("wr_pulse", RW'(reg_wr_pulse), RW'(be.pulse));
                  compare("reg_out", reg_out, be.regs);
               end
            end else if (s_axi_bvalid) begin
               compare("pulse_one_cycle", RW'(reg_wr_pulse), '0);
            end
            if (s_axi_rvalid && !rv_prev) begin
               if (r_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL r_unexpected: got rvalid=1 expected no response");
               end else begin
                  re = r_q.pop_front();
                  compare("rdata", RW'(s_axi_rdata), RW'(re.data));
                  compare("rresp", RW'(s_axi_rresp), RW'(re.resp));
                  rhold = s_axi_rdata;
               end
            end else if (s_axi_rvalid) begin
               compare("rdata_stable", RW'(s_axi_rdata), RW'(rhold));
            end
         end
         bv_prev = s_axi_bvalid;
         rv_prev = s_axi_rvalid;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      chk_t c;
      c.name = name; c.act = act; c.exp = exp;
      chk_q.push_back(c);
   endtask

   task automatic expect_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
      b_exp_t e;
      int idx;
      logic ok;
      idx = int'(a[4:2]);
      ok  = (a[12:5] == '0);
      if (ok)
         for (int b = 0; b < 4; b++)
            if (s[b]) model[idx*32 + b*8 +: 8] = d[b*8 +: 8];
      e.resp  = ok ? 2'b00 : 2'b10;
      e.pulse = ok ? (NR'(1) << idx) : '0;
      e.regs  = model;
      b_q.push_back(e);
   endtask

   task automatic expect_read(input logic [12:0] a);
      r_exp_t e;
      int idx;
      logic ok;
      idx = int'(a[4:2]);
      ok  = (a[12:5] == '0);
      e.data = ok ? model[idx*32 +: 32] : 32'h0;
      e.resp = ok ? 2'b00 : 2'b10;
      r_q.push_back(e);
   endtask

   // Each send is entered at a negedge and returns at the negedge after its handshake
   task automatic aw_send(input logic [12:0] a);
      int n = 0;
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("aw_timeout", RW'(s_axi_awready), RW'(1));
      @(negedge clk);
      s_axi_awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_timeout", RW'(s_axi_wready), RW'(1));
      @(negedge clk);
      s_axi_wvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [12:0] a);
      int n = 0;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("ar_timeout", RW'(s_axi_arready), RW'(1));
      @(negedge clk);
      s_axi_arvalid = 1'b0;
   endtask

   task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
      expect_write(a, d, s);
      fork
         aw_send(a);
         w_send(d, s);
      join
      repeat (3) @(negedge clk);
   endtask

   task automatic rd(input logic [12:0] a);
      expect_read(a);
      ar_send(a);
      repeat (3) @(negedge clk);
   endtask

   // ---------------- directed vectors ----------------
   initial begin : stim
      #2;
      chk("rst_awready", RW'(s_axi_awready), '0);
      chk("rst_bvalid", RW'(s_axi_bvalid), '0);
      chk("rst_rvalid", RW'(s_axi_rvalid), '0);
      chk("rst_reg_out", reg_out, '0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk("ready_at_release", RW'({s_axi_awready, s_axi_wready, s_axi_arready}), '0);
      @(negedge clk);
      chk("ready_after_release", RW'({s_axi_awready, s_axi_wready, s_axi_arready}), RW'(3'b111));

      // AW and W together to reg 2
      wr(13'h008, 32'hDEADBEEF, 4'hF);

      // W three cycles ahead of AW, low half only
      expect_write(13'h008, 32'h0000ABCD, 4'h3);
      w_send(32'h0000ABCD, 4'h3);
      repeat (3) begin
         chk("w_held_wready", RW'(s_axi_wready), '0);
         chk("w_held_no_b", RW'(s_axi_bvalid), '0);
         chk("w_held_no_pulse", RW'(reg_wr_pulse), '0);
         chk("w_held_reg2", RW'(reg_out[95:64]), RW'(32'hDEADBEEF));
         @(negedge clk);
      end
      aw_send(13'h008);
      repeat (3) @(negedge clk);

      // Read reg 2 with rready held low
      s_axi_rready = 1'b0;
      expect_read(13'h008);
      ar_send(13'h008);
      repeat (4) begin
         chk("rhold_arready", RW'(s_axi_arready), '0);
         chk("rhold_rvalid", RW'(s_axi_rvalid), RW'(1));
         @(negedge clk);
      end
      s_axi_rready = 1'b1;
      @(negedge clk);
      chk("arready_back", RW'(s_axi_arready), RW'(1));
      chk("rvalid_drop", RW'(s_axi_rvalid), '0);
      repeat (2) @(negedge clk);

      // Out of range write and read
      wr(13'h040, 32'h12345678, 4'hF);
      rd(13'h040);

      // AW ahead of W, top byte only, addr[1:0] ignored
      expect_write(13'h01F, 32'hA5000000, 4'h8);
      aw_send(13'h01F);
      @(negedge clk);
      w_send(32'hA5000000, 4'h8);
      repeat (3) @(negedge clk);
      rd(13'h01C);

      // Zero strobe still pulses, no change
      wr(13'h014, 32'hFFFFFFFF, 4'h0);

      // Concurrent write and read of reg 0: read sees the old value
      expect_read(13'h000);
      expect_write(13'h000, 32'h11111111, 4'hF);
      fork
         aw_send(13'h000);
         w_send(32'h11111111, 4'hF);
         ar_send(13'h000);
      join
      repeat (3) @(negedge clk);
      rd(13'h000);

      // Reset while B is waiting
      s_axi_bready = 1'b0;
      expect_write(13'h00C, 32'hCAFEF00D, 4'hF);
      fork
         aw_send(13'h00C);
         w_send(32'hCAFEF00D, 4'hF);
      join
      repeat (2) @(negedge clk);
      chk("b_held", RW'(s_axi_bvalid), RW'(1));
      rst = 1'b0;
      #1;
      model = '0;
      chk("rst_mid_bvalid", RW'(s_axi_bvalid), '0);
      chk("rst_mid_regs", reg_out, '0);
      chk("rst_mid_awready", RW'(s_axi_awready), '0);
      @(negedge clk);
      rst = 1'b1;
      s_axi_bready = 1'b1;
      @(negedge clk);
      chk("awready_post_rst", RW'(s_axi_awready), RW'(1));
      chk("wready_post_rst", RW'(s_axi_wready), RW'(1));

      // Block works again after reset
      wr(13'h004, 32'h0BADF00D, 4'hF);
      rd(13'h004);
      rd(13'h00C);

      repeat (3) @(negedge clk);
      chk("b_queue_drained", RW'(b_q.size()), '0);
      chk("r_queue_drained", RW'(r_q.size()), '0);
      repeat (3) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
